// File: rtl/bytecode_fetch_ctrl_pkg.sv
// Shared state encoding and opcode constants for the bytecode fetch front end.
package bytecode_fetch_ctrl_pkg;

    localparam int FC_ADR_W_DEFAULT = 12;
    localparam int FC_MAX_PARAMS    = 4;

    localparam logic [7:0] OP_TABLESWITCH  = 8'hAA;
    localparam logic [7:0] OP_LOOKUPSWITCH = 8'hAB;
    localparam logic [7:0] OP_WIDE         = 8'hC4;
    localparam logic [7:0] OP_UNDEF_FIRST  = 8'hCB;
    localparam logic [7:0] OP_UNDEF_LAST   = 8'hFD;

    typedef enum logic [2:0] {
        FC_IDLE,
        FC_OP_RD,
        FC_OP_CAP,
        FC_PAR_RD,
        FC_PAR_CAP,
        FC_PRESENT,
        FC_DONE,
        FC_ERROR
    } fc_state_t;

    function automatic logic fc_is_busy(input fc_state_t s);
        return !(s inside {FC_IDLE, FC_DONE, FC_ERROR});
    endfunction

endpackage

// File: rtl/bytecode_fetch_ctrl_param_len.sv
// Opcode to operand-byte-count decoder; variable-length opcodes are flagged
// as unsupported rather than given a length.
module bytecode_param_len
    import bytecode_fetch_ctrl_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] len,
    output logic       unsupported
);

    always_comb begin
        len         = 3'd0;
        unsupported = 1'b0;
        case (opcode) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                len = 3'd1;
            8'h11, [8'h13:8'h14], 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, [8'hC0:8'hC1], [8'hC6:8'hC7]:
                len = 3'd2;
            8'hC5:
                len = 3'd3;
            [8'hB9:8'hBA], [8'hC8:8'hC9]:
                len = 3'd4;
            OP_TABLESWITCH, OP_LOOKUPSWITCH, OP_WIDE, [OP_UNDEF_FIRST:OP_UNDEF_LAST]:
                unsupported = 1'b1;
            default:
                len = 3'd0;
        endcase
    end

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Walks a bytecode method in IRAM, gathers each opcode with its operands and
// hands complete instructions to the translator over a valid/waiting handshake.
module bytecode_fetch_ctrl
    import bytecode_fetch_ctrl_pkg::*;
#(
    parameter int IRAM_ADR_W = FC_ADR_W_DEFAULT,
    parameter int MAX_PARAMS = FC_MAX_PARAMS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IRAM_ADR_W-1:0]   start_adr,
    input  logic [IRAM_ADR_W-1:0]   len_bytes,
    output logic                    iram_rd,
    output logic [IRAM_ADR_W-1:0]   iram_adr,
    input  logic [7:0]              iram_data,
    output logic [7:0]              jvm_opcode,
    output logic [7:0]              parameter_number,
    output logic [8*MAX_PARAMS-1:0] params,
    output logic [IRAM_ADR_W-1:0]   op_pc,
    output logic                    op_valid,
    input  logic                    waiting,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [IRAM_ADR_W-1:0]   err_pc
);

    localparam int K_W = $clog2(MAX_PARAMS);

    fc_state_t               state_q, state_d;
    logic [IRAM_ADR_W-1:0]   pc_q, pc_d;
    logic [IRAM_ADR_W-1:0]   end_q, end_d;
    logic [IRAM_ADR_W-1:0]   err_pc_q, err_pc_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [2:0]              n_q, n_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [8*MAX_PARAMS-1:0] params_q, params_d;

    logic [2:0]              pl_len;
    logic                    pl_unsup;
    logic [IRAM_ADR_W-1:0]   remaining;
    logic [IRAM_ADR_W:0]     need;
    logic [IRAM_ADR_W-1:0]   pc_next;

    bytecode_param_len u_param_len (
        .opcode      (iram_data),
        .len         (pl_len),
        .unsupported (pl_unsup)
    );

    // Bytes left before end, modulo the address space so wrapped ranges work.
    assign remaining = end_q - pc_q;
    assign need      = (IRAM_ADR_W+1)'(pl_len) + (IRAM_ADR_W+1)'(1);
    assign pc_next   = pc_q + IRAM_ADR_W'(n_q) + IRAM_ADR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FC_IDLE;
            pc_q     <= '0;
            end_q    <= '0;
            err_pc_q <= '0;
            k_q      <= '0;
            n_q      <= '0;
            opcode_q <= '0;
            params_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            end_q    <= end_d;
            err_pc_q <= err_pc_d;
            k_q      <= k_d;
            n_q      <= n_d;
            opcode_q <= opcode_d;
            params_q <= params_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        end_d    = end_q;
        err_pc_d = err_pc_q;
        k_d      = k_q;
        n_d      = n_q;
        opcode_d = opcode_q;
        params_d = params_q;
        case (state_q)
            FC_IDLE, FC_DONE, FC_ERROR: begin
                if (start) begin
                    pc_d     = start_adr;
                    end_d    = start_adr + len_bytes;
                    err_pc_d = '0;
                    opcode_d = '0;
                    n_d      = '0;
                    params_d = '0;
                    state_d  = (len_bytes == '0) ? FC_DONE : FC_OP_RD;
                end
            end
            FC_OP_RD:
                state_d = FC_OP_CAP;
            FC_OP_CAP: begin
                opcode_d = iram_data;
                n_d      = pl_len;
                k_d      = '0;
                if (pl_unsup || ({1'b0, remaining} < need)) begin
                    err_pc_d = pc_q;
                    state_d  = FC_ERROR;
                end else if (pl_len == 3'd0) begin
                    state_d = FC_PRESENT;
                end else begin
                    state_d = FC_PAR_RD;
                end
            end
            FC_PAR_RD:
                state_d = FC_PAR_CAP;
            FC_PAR_CAP: begin
                params_d[8*k_q +: 8] = iram_data;
                if (3'(k_q) == n_q - 3'd1) begin
                    state_d = FC_PRESENT;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = FC_PAR_RD;
                end
            end
            FC_PRESENT: begin
                if (!waiting) begin
                    pc_d     = pc_next;
                    params_d = '0;
                    state_d  = (pc_next == end_q) ? FC_DONE : FC_OP_RD;
                end
            end
            default:
                state_d = FC_IDLE;
        endcase
    end

    always_comb begin
        iram_rd  = 1'b0;
        iram_adr = '0;
        case (state_q)
            FC_OP_RD: begin
                iram_rd  = 1'b1;
                iram_adr = pc_q;
            end
            FC_PAR_RD: begin
                iram_rd  = 1'b1;
                iram_adr = pc_q + IRAM_ADR_W'(k_q) + IRAM_ADR_W'(1);
            end
            default: ;
        endcase
    end

    assign jvm_opcode       = opcode_q;
    assign parameter_number = {5'b0, n_q};
    assign params           = params_q;
    assign op_pc            = pc_q;
    assign op_valid         = (state_q == FC_PRESENT);
    assign busy             = fc_is_busy(state_q);
    assign done             = (state_q == FC_DONE);
    assign error            = (state_q == FC_ERROR);
    assign err_pc           = err_pc_q;

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Directed and randomized bench for bytecode_fetch_ctrl; expectations come from
// an offset-based walk of an IRAM image kept in the bench.
module tb_bytecode_fetch_ctrl;

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  n;
      logic [31:0] prm;
      logic [11:0] pc;
   } instr_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [11:0] start_adr;
   logic [11:0] len_bytes;
   logic        iram_rd;
   logic [11:0] iram_adr;
   logic [7:0]  iram_data;
   logic [7:0]  jvm_opcode;
   logic [7:0]  parameter_number;
   logic [31:0] params;
   logic [11:0] op_pc;
   logic        op_valid;
   logic        waiting;
   logic        busy;
   logic        done;
   logic        error;
   logic [11:0] err_pc;

   logic [7:0]  mem [0:4095];
   instr_t      expQ[$];
   bit          expErr;
   logic [11:0] expErrPc;
   int          vectors;
   int          miscompares;

   bytecode_fetch_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .start_adr        (start_adr),
      .len_bytes        (len_bytes),
      .iram_rd          (iram_rd),
      .iram_adr         (iram_adr),
      .iram_data        (iram_data),
      .jvm_opcode       (jvm_opcode),
      .parameter_number (parameter_number),
      .params           (params),
      .op_pc            (op_pc),
      .op_valid         (op_valid),
      .waiting          (waiting),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .err_pc           (err_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IRAM returns the addressed byte one cycle after a read, noise otherwise.
   always @(posedge clk) begin
      if (iram_rd) iram_data <= mem[iram_adr];
      else         iram_data <= 8'($urandom);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Operand count per opcode from the JVM instruction table; -1 = unsupported.
   function automatic int refLen(input logic [7:0] op);
      if (op == 8'hAA || op == 8'hAB || op == 8'hC4 || (op >= 8'hCB && op <= 8'hFD)) return -1;
      if (op == 8'hC5) return 3;
      if (op inside {8'hB9, 8'hBA, 8'hC8, 8'hC9}) return 4;
      if (op inside {8'h10, 8'h12, 8'hA9, 8'hBC} || (op >= 8'h15 && op <= 8'h19) ||
          (op >= 8'h36 && op <= 8'h3A)) return 1;
      if (op inside {8'h11, 8'h13, 8'h14, 8'h84, 8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7} ||
          (op >= 8'h99 && op <= 8'hA8) || (op >= 8'hB2 && op <= 8'hB8)) return 2;
      return 0;
   endfunction

   task automatic buildModel(input logic [11:0] sa, input int len);
      int off;
      int n;
      logic [7:0] op;
      instr_t it;
      off = 0;
      expQ.delete();
      expErr = 1'b0;
      expErrPc = '0;
      while (off < len) begin
         op = mem[12'(int'(sa) + off)];
         n = refLen(op);
         if (n < 0 || off + 1 + n > len) begin
            expErr = 1'b1;
            expErrPc = 12'(int'(sa) + off);
            break;
         end
         it.op = op;
         it.n = 3'(n);
         it.pc = 12'(int'(sa) + off);
         it.prm = '0;
         for (int j = 0; j < n; j++) it.prm[8*j +: 8] = mem[12'(int'(sa) + off + 1 + j)];
         expQ.push_back(it);
         off += 1 + n;
      end
   endtask

   // Runs one method from start pulse to done/error, checking every instruction.
   task automatic applyStimulus(input logic [11:0] sa, input logic [11:0] len,
                                input int holdCycles, input bit pokeStart);
      int cycles;
      int reads;
      logic [11:0] basePc;
      instr_t e;
      buildModel(sa, int'(len));
      start = 1'b1;
      start_adr = sa;
      len_bytes = len;
      tick();
      start = 1'b0;
      start_adr = 12'($urandom);
      len_bytes = 12'($urandom);
      checkOutput("error_after_start", {31'b0, error}, 32'd0);
      checkOutput("err_pc_after_start", {20'b0, err_pc}, 32'd0);
      for (int idx = 0; idx <= expQ.size(); idx++) begin
         cycles = 0;
         reads = 0;
         basePc = (idx < expQ.size()) ? expQ[idx].pc : expErrPc;
         while (!op_valid && !done && !error && cycles < 40) begin
            if (iram_rd) begin
               checkOutput("iram_adr", {20'b0, iram_adr}, {20'b0, basePc + 12'(reads)});
               reads++;
            end else begin
               checkOutput("iram_adr_idle", {20'b0, iram_adr}, 32'd0);
            end
            if (pokeStart && idx == 0 && cycles == 3) begin
               start = 1'b1;
               start_adr = 12'h300;
               len_bytes = 12'd1;
            end
            tick();
            start = 1'b0;
            cycles++;
         end
         if (idx < expQ.size()) begin
            e = expQ[idx];
            checkOutput("op_valid", {31'b0, op_valid}, 32'd1);
            checkOutput("latency", cycles, 2 * (int'(e.n) + 1));
            checkOutput("read_count", reads, int'(e.n) + 1);
            checkOutput("jvm_opcode", {24'b0, jvm_opcode}, {24'b0, e.op});
            checkOutput("parameter_number", {24'b0, parameter_number}, {29'b0, e.n});
            checkOutput("params", params, e.prm);
            checkOutput("op_pc", {20'b0, op_pc}, {20'b0, e.pc});
            checkOutput("busy_present", {31'b0, busy}, 32'd1);
            for (int h = 0; h < holdCycles; h++) begin
               tick();
               checkOutput("hold_valid", {31'b0, op_valid}, 32'd1);
               checkOutput("hold_no_read", {31'b0, iram_rd}, 32'd0);
               checkOutput("hold_opcode", {24'b0, jvm_opcode}, {24'b0, e.op});
               checkOutput("hold_params", params, e.prm);
               checkOutput("hold_op_pc", {20'b0, op_pc}, {20'b0, e.pc});
            end
            waiting = 1'b0;
            tick();
            waiting = 1'b1;
         end else begin
            checkOutput("done", {31'b0, done}, {31'b0, !expErr});
            checkOutput("error", {31'b0, error}, {31'b0, expErr});
            checkOutput("end_valid", {31'b0, op_valid}, 32'd0);
            checkOutput("end_busy", {31'b0, busy}, 32'd0);
            if (expErr) begin
               checkOutput("err_pc", {20'b0, err_pc}, {20'b0, expErrPc});
               checkOutput("err_latency", cycles, 2);
            end
         end
      end
   endtask

   task automatic genMethod(input logic [11:0] sa, input int len);
      int g;
      int n;
      logic [7:0] op;
      g = 0;
      while (g < len + 5) begin
         op = 8'($urandom);
         while (refLen(op) < 0 && $urandom_range(0, 9) != 0) op = 8'($urandom);
         mem[12'(int'(sa) + g)] = op;
         g++;
         n = refLen(op);
         for (int j = 0; j < n; j++) begin
            mem[12'(int'(sa) + g)] = 8'($urandom);
            g++;
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b0;
      start = 1'b0;
      start_adr = '0;
      len_bytes = '0;
      waiting = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      tick();
      tick();
      checkOutput("rst_op_valid", {31'b0, op_valid}, 32'd0);
      checkOutput("rst_iram_rd", {31'b0, iram_rd}, 32'd0);
      checkOutput("rst_iram_adr", {20'b0, iram_adr}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      checkOutput("rst_opcode", {24'b0, jvm_opcode}, 32'd0);
      checkOutput("rst_params", params, 32'd0);
      reset = 1'b1;
      tick();

      mem[12'h010] = 8'h60;
      applyStimulus(12'h010, 12'd1, 0, 1'b0);

      mem[12'h020] = 8'h10; mem[12'h021] = 8'h05;
      mem[12'h022] = 8'h11; mem[12'h023] = 8'h12; mem[12'h024] = 8'h34;
      applyStimulus(12'h020, 12'd5, 7, 1'b0);

      mem[12'h040] = 8'hC8; mem[12'h041] = 8'h00; mem[12'h042] = 8'h00;
      mem[12'h043] = 8'h01; mem[12'h044] = 8'h00;
      applyStimulus(12'h040, 12'd5, 0, 1'b1);

      mem[12'h060] = 8'h11; mem[12'h061] = 8'h22;
      applyStimulus(12'h060, 12'd2, 0, 1'b0);
      applyStimulus(12'h010, 12'd1, 0, 1'b0);

      mem[12'h070] = 8'hAA;
      applyStimulus(12'h070, 12'd4, 0, 1'b0);
      applyStimulus(12'h020, 12'd5, 1, 1'b0);

      applyStimulus(12'h100, 12'd0, 0, 1'b0);

      mem[12'hFFE] = 8'h10; mem[12'hFFF] = 8'h05; mem[12'h000] = 8'h60;
      applyStimulus(12'hFFE, 12'd3, 0, 1'b0);

      start = 1'b1;
      start_adr = 12'h040;
      len_bytes = 12'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      checkOutput("mid_par_rd", {31'b0, iram_rd}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abort_valid", {31'b0, op_valid}, 32'd0);
      checkOutput("abort_iram_rd", {31'b0, iram_rd}, 32'd0);
      checkOutput("abort_iram_adr", {20'b0, iram_adr}, 32'd0);
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_opcode", {24'b0, jvm_opcode}, 32'd0);
      checkOutput("abort_op_pc", {20'b0, op_pc}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("post_rst_done", {31'b0, done}, 32'd0);
      applyStimulus(12'h010, 12'd1, 0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         logic [11:0] sa;
         int len;
         sa = 12'($urandom);
         len = $urandom_range(1, 20);
         genMethod(sa, len);
         applyStimulus(sa, 12'(len), $urandom_range(0, 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bytecode_fetch_ctrl.md
Name: bytecode_fetch_ctrl

Overview:
Front-end sequencer for the bytecode translator state machine. Walks a JVM method held in IRAM from a host-given start address and reads each opcode byte. Determines that opcode's operand-byte count, collects the operands, and presents one complete instruction (opcode, parameter_number, packed operands, pc) to the translator with a valid/waiting handshake. Stops at the end of the range, or flags an error on unsupported or truncated instructions.

Parameters:
IRAM_ADR_W, 12, IRAM byte-address width
MAX_PARAMS, 4, maximum operand bytes per instruction (fixed at 4; params bus is 8*MAX_PARAMS)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle pulse; latches start_adr/len_bytes and begins fetch (ignored unless IDLE/DONE/ERROR)
start_adr  in  IRAM_ADR_W  first bytecode address
len_bytes  in  IRAM_ADR_W  method length in bytes; 0 means go directly to DONE
iram_rd  out  1  IRAM read strobe
iram_adr  out  IRAM_ADR_W  IRAM read address
iram_data  in  8  IRAM read data; valid exactly one cycle after iram_rd
jvm_opcode  out  8  presented opcode
parameter_number  out  8  operand byte count of presented opcode (0..4)
params  out  8*MAX_PARAMS  operands; byte k at [8k+7:8k], unused bytes 0
op_pc  out  IRAM_ADR_W  address of presented opcode
op_valid  out  1  instruction presented
waiting  in  1  translator busy; instruction consumed on a cycle with op_valid=1 and waiting=0
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  level; high in DONE
error  out  1  level; high in ERROR
err_pc  out  IRAM_ADR_W  pc of the offending opcode

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; pc, end, k cleared.
- start: pc<=start_adr, end<=start_adr+len_bytes (mod 2^IRAM_ADR_W, wrap permitted). Next state is OP_RD, or DONE if len_bytes=0.
- OP_RD: iram_rd=1, iram_adr=pc, then OP_CAP.
- OP_CAP: capture iram_data into the opcode register; n = param_len(opcode).
  - n is unsupported (0xAA tableswitch, 0xAB lookupswitch, 0xC4 wide, undefined 0xCB-0xFD): go to ERROR, err_pc=pc.
  - pc+1+n exceeds end (distance computed modulo 2^IRAM_ADR_W from start): go to ERROR, err_pc=pc.
  - n=0: go to PRESENT.
  - otherwise: k<=0, go to PAR_RD.
- PAR_RD: iram_rd=1, iram_adr=pc+1+k, then PAR_CAP.
- PAR_CAP: params byte k <= iram_data. If k=n-1 go to PRESENT; else k++ and go to PAR_RD.
- PRESENT: op_valid=1.
  - jvm_opcode, parameter_number, params and op_pc are stable while op_valid=1.
  - waiting=0 consumes the instruction: pc<=pc+1+n, params cleared. Next state is DONE if the new pc=end, else OP_RD.
  - waiting=1 holds PRESENT indefinitely.
- Latency: op_valid rises 2(n+1) cycles after entering OP_RD. Back-to-back instructions: the next OP_RD begins the cycle after consume.
- iram_rd is never asserted outside OP_RD/PAR_RD; iram_adr is 0 when iram_rd=0.
- DONE/ERROR: sticky until start or reset. start in these states clears done/error/err_pc and restarts.
- start while busy: ignored.
- Reset mid-operation: immediate abort, no further reads, op_valid drops asynchronously.

Decomposition:
- me_consts.vh: IRAM_ADR_W default, MAX_PARAMS, state encodings (`FC_IDLE .. `FC_ERROR, 3 bits), opcode constants for unsupported ops.
- Sub-module bytecode_param_len: combinational 8-bit opcode to 3-bit length plus unsupported flag, full 256-entry case.
  - 1 byte: bipush, ldc, load/store index, newarray, ret.
  - 2 bytes: sipush, ldc_w/ldc2_w, iinc, branches/if*, jsr, get/put field/static, invokevirtual/special/static, new, anewarray, checkcast, instanceof.
  - 3 bytes: multianewarray.
  - 4 bytes: goto_w, jsr_w, invokeinterface, invokedynamic.
- Controller FSM and datapath live in bytecode_fetch_ctrl.

Test Plan:
- IRAM[0x10]=0x60 (iadd), start_adr=0x10, len=1, waiting=0 -> op_valid 2 cycles after OP_RD with opcode 0x60, parameter_number 0, params 0, op_pc 0x10; then done=1.
- IRAM[0x20..0x24]=0x10 0x05 0x11 0x12 0x34, len=5 -> first instruction bipush with params=0x00000005 and op_pc 0x20; second sipush with params=0x00003412 and op_pc 0x22; then done.
- goto_w 0xC8 0x00 0x00 0x01 0x00 -> parameter_number 4, params 0x00010000, op_valid 10 cycles after OP_RD.
- Hold waiting=1 for 7 cycles during PRESENT -> outputs stable, no iram_rd during the hold; consumed on the first waiting=0 cycle.
- Truncation: sipush at the last byte, len=2 -> error=1, err_pc=start_adr, op_valid never asserted. Unsupported: tableswitch 0xAA -> error. In both cases a new start pulse clears the error and restarts.
- Pull reset=0 mid-PAR_RD -> all outputs 0 immediately; after release, state IDLE and start is accepted normally.
